// File: rtl/uart_rx_buf_if.sv
// Receive-side handshake bundle between uart_rx_buf (master) and its consumer (slave).
interface uart_rx_buf_if #(
   parameter int PAYLOAD_BITS = 8,
   parameter int FIFO_DEPTH   = 4
) ();
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic                    rx_read;
   logic                    rx_valid;
   logic [PAYLOAD_BITS-1:0] rx_data;
   logic                    rx_frame_err;
   logic                    rx_parity_err;
   logic                    rx_overflow;
   logic                    rx_ovf_clr;
   logic [LW-1:0]           rx_level;

   modport master (
      input  rx_read, rx_ovf_clr,
      output rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overflow, rx_level
   );

   modport slave (
      output rx_read, rx_ovf_clr,
      input  rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overflow, rx_level
   );
endinterface

// File: rtl/uart_rx_buf.sv
// UART receiver feeding a first-word-fall-through FIFO with per-entry error flags and RTS flow control.
// Optional 2-of-3 majority bit sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx_buf #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int BIT_RATE     = 9600,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY       = 0,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          uart_rxd,
   output logic          uart_rts,
   uart_rx_buf_if.master rx
);
   localparam int CPB = CLK_HZ / BIT_RATE;
   localparam int CW  = $clog2(CPB);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int LW  = PW + 1;
   localparam int EW  = PAYLOAD_BITS + 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int SAMPLE_AT = CPB / 2 + 1;
`else
   localparam int SAMPLE_AT = CPB / 2;
`endif
   localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_AT);
   localparam logic [CW-1:0] CNT_LAST   = CW'(CPB - 1);
   localparam logic [3:0]    LAST_DATA  = 4'(PAYLOAD_BITS - 1);
   localparam logic [3:0]    LAST_STOP  = 4'(STOP_BITS - 1);
   localparam logic          ODD_PAR    = (PARITY == 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [1:0] sync_q, sync_d;
   logic       rxd_s;
   logic       bit_val;

   state_t                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [3:0]              bit_idx_q;
   logic [PAYLOAD_BITS-1:0] shift_q;
   logic                    frame_err_q;
   logic                    par_err_q;
   logic                    wait_high_q;

   logic          push;
   logic [EW-1:0] push_word;

   always_comb sync_d = {sync_q[0], uart_rxd};

   always_ff @(posedge clk) begin
      if (!resetn) sync_q <= 2'b11;
      else         sync_q <= sync_d;
   end

   assign rxd_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] maj_q, maj_d;

   // Two early samples are held; the third is the live value at the decision count.
   always_comb begin
      maj_d = maj_q;
      if (cnt_q == CW'(CPB / 2 - 1)) maj_d[0] = rxd_s;
      if (cnt_q == CW'(CPB / 2))     maj_d[1] = rxd_s;
   end

   always_ff @(posedge clk) begin
      if (!resetn) maj_q <= 2'b11;
      else         maj_q <= maj_d;
   end

   assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rxd_s) | (maj_q[1] & rxd_s);
`else
   assign bit_val = rxd_s;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         par_err_q   <= 1'b0;
         wait_high_q <= 1'b0;
      end else begin
         cnt_q <= (state_q == S_IDLE || cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
         case (state_q)
            S_IDLE: begin
               // After a low stop bit the line must be seen high before a new start is trusted.
               if (wait_high_q) begin
                  if (rxd_s) wait_high_q <= 1'b0;
               end else if (!rxd_s) begin
                  state_q     <= S_START;
                  bit_idx_q   <= '0;
                  frame_err_q <= 1'b0;
                  par_err_q   <= 1'b0;
               end
            end
            S_START: begin
               if (cnt_q == CNT_SAMPLE && bit_val) state_q <= S_IDLE;
               else if (cnt_q == CNT_LAST)         state_q <= S_DATA;
            end
            S_DATA: begin
               if (cnt_q == CNT_SAMPLE) shift_q <= {bit_val, shift_q[PAYLOAD_BITS-1:1]};
               if (cnt_q == CNT_LAST) begin
                  if (bit_idx_q == LAST_DATA) begin
                     bit_idx_q <= '0;
                     state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 4'd1;
                  end
               end
            end
            S_PARITY: begin
               if (cnt_q == CNT_SAMPLE) par_err_q <= (^{shift_q, bit_val}) ^ ODD_PAR;
               if (cnt_q == CNT_LAST)   state_q   <= S_STOP;
            end
            S_STOP: begin
               if (cnt_q == CNT_SAMPLE && !bit_val) frame_err_q <= 1'b1;
               if (cnt_q == CNT_SAMPLE && bit_idx_q == LAST_STOP) begin
                  state_q     <= S_IDLE;
                  bit_idx_q   <= '0;
                  wait_high_q <= frame_err_q | ~bit_val;
               end else if (cnt_q == CNT_LAST) begin
                  bit_idx_q <= bit_idx_q + 4'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // The frame is pushed on the last stop sample itself, so the current sample joins frame_err.
   assign push      = (state_q == S_STOP) && (cnt_q == CNT_SAMPLE) && (bit_idx_q == LAST_STOP);
   assign push_word = {par_err_q, frame_err_q | ~bit_val, shift_q};

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [EW-1:0] head_q, head_d;
   logic          valid_q, valid_d;
   logic          ovf_q, ovf_d;
   logic          rts_q, rts_d;
   logic          pop, full, wr_en;

   always_comb begin
      pop      = rx.rx_read && valid_q;
      full     = (level_q == LW'(FIFO_DEPTH));
      wr_en    = push && (!full || pop);
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      level_d  = level_q + LW'(wr_en) - LW'(pop);
      valid_d  = (level_d != '0);
      // Head register holds the next entry; bypass when that entry is being written now.
      if (level_d == '0)                       head_d = head_q;
      else if (wr_en && wr_ptr_q == rd_ptr_d)  head_d = push_word;
      else                                     head_d = mem[rd_ptr_d];
      if (push && full && !pop) ovf_d = 1'b1;
      else if (rx.rx_ovf_clr)   ovf_d = 1'b0;
      else                      ovf_d = ovf_q;
      rts_d = (level_q >= LW'(FIFO_DEPTH - 1));
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= push_word;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         rts_q    <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         rts_q    <= rts_d;
      end
   end

   assign rx.rx_valid      = valid_q;
   assign rx.rx_data       = head_q[PAYLOAD_BITS-1:0];
   assign rx.rx_frame_err  = head_q[PAYLOAD_BITS];
   assign rx.rx_parity_err = head_q[PAYLOAD_BITS+1];
   assign rx.rx_overflow   = ovf_q;
   assign rx.rx_level      = level_q;
   assign uart_rts         = rts_q;
endmodule

// File: doc/uart_rx_buf.md
UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 9600, line bit rate; CPB = CLK_HZ/BIT_RATE (integer division, CPB >= 8).
REQ-003 Parameter PAYLOAD_BITS, default 8, data bits per frame, range 5..9.
REQ-004 Parameter STOP_BITS, default 1, range 1..2.
REQ-005 Parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-006 Parameter FIFO_DEPTH, default 4, power of two, range 2..16.
REQ-007 clk  input  1  system clock.
REQ-008 resetn  input  1  reset, synchronous, active-low.
REQ-009 uart_rxd  input  1  asynchronous serial line, idle high.
REQ-010 uart_rts  output  1  request-to-send, active low.
REQ-011 rx_read  input  1  pop head FIFO entry; ignored when rx_valid = 0.
REQ-012 rx_valid  output  1  FIFO non-empty.
REQ-013 rx_data  output  PAYLOAD_BITS  head-entry data, LSB = first received bit.
REQ-014 rx_frame_err  output  1  head entry had a low stop bit.
REQ-015 rx_parity_err  output  1  head entry failed parity; constant 0 when PARITY = 0.
REQ-016 rx_overflow  output  1  sticky: a frame was dropped because the FIFO was full.
REQ-017 rx_ovf_clr  input  1  clears rx_overflow.
REQ-018 rx_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-019 uart_rxd shall pass through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-020 FSM states: IDLE, START, DATA, PARITY, STOP; a bit counter tracks the DATA and STOP bit index.
REQ-021 IDLE -> START on synchronised low; the cycle counter restarts at 0.
REQ-022 The cycle counter counts 0..CPB-1 per bit; sampling occurs at count CPB/2.
REQ-023 START: a high sample at mid-bit is a glitch -> IDLE, with nothing pushed; a low sample -> DATA at count CPB-1.
REQ-024 DATA: PAYLOAD_BITS samples, LSB first -> PARITY if PARITY != 0, else STOP.
REQ-025 PARITY: the sampled bit is checked against the XOR of the data bits (odd: XOR of data and parity bit = 1; even: = 0).
REQ-026 STOP: each of STOP_BITS bits is sampled at mid-bit; any low sample sets frame_err for the frame.
REQ-027 On the mid-bit sample of the last stop bit: push {parity_err, frame_err, data} and go to IDLE in the same cycle, without waiting for the bit end.
REQ-028 If frame_err is set and the line is still low on return to IDLE, the next start bit is detected only after the line has first been seen high.
REQ-029 rx_valid, rx_data and both error flags update in the cycle after the push edge (registered FIFO head, first-word fall-through).
REQ-030 A pop is rx_read && rx_valid; the next entry, or rx_valid = 0, appears in the following cycle.
REQ-031 Push when full and no pop: the frame is dropped, rx_overflow <= 1, and the FIFO contents are unchanged.
REQ-032 Push when full with a simultaneous pop: both succeed, rx_level is unchanged, and there is no overflow.
REQ-033 rx_ovf_clr coinciding with a new overflow: set wins.
REQ-034 uart_rts <= 1 (deassert) when rx_level >= FIFO_DEPTH-1, else 0; registered, one-cycle lag.
REQ-035 Pointers shall wrap modulo FIFO_DEPTH; rx_level ranges 0..FIFO_DEPTH.

Reset
REQ-036 With resetn low at a clk edge: FSM -> IDLE, counters = 0, synchroniser = 2'b11, FIFO empty.
REQ-037 Reset output values: rx_valid = 0, rx_data = 0, rx_frame_err = 0, rx_parity_err = 0, rx_overflow = 0, rx_level = 0, uart_rts = 1.
REQ-038 Reset mid-frame shall discard the partial frame; reception resumes at the next falling edge after reset release.

Configuration
REQ-039 Macro UART_RX_MAJORITY_EN: when defined, each bit value (start, data, parity, stop) is the 2-of-3 majority of samples at counts CPB/2-1, CPB/2 and CPB/2+1; FSM decisions, including glitch rejection and the last-stop push, occur at count CPB/2+1.
REQ-040 Without UART_RX_MAJORITY_EN, a single sample at count CPB/2 is used and the majority logic is absent.

Verification (bench: CLK_HZ=1_000_000, BIT_RATE=100_000, CPB=10)
REQ-041 Defaults, receive 0xA5 -> rx_valid rises 1 cycle after the stop mid-sample; rx_data = 0xA5; both error flags 0; rx_level = 1.
REQ-042 PARITY=2, receive 0x03 with parity bit 1 -> rx_parity_err = 1, rx_data = 0x03; with parity bit 0 -> rx_parity_err = 0.
REQ-043 Stop bit held low, data 0x55 -> entry pushed with rx_frame_err = 1; next frame 0x12, sent after the line returns high, is received cleanly.
REQ-044 FIFO_DEPTH=4, five frames 0x01..0x05 with no reads -> uart_rts = 1 after the 3rd frame; rx_overflow = 1 after the 5th; pops return 0x01..0x04.
REQ-045 Start glitch low for 3 cycles -> no push; rx_level = 0. With UART_RX_MAJORITY_EN, a 1-cycle high spike at count 5 of data bit 0 is rejected.
REQ-046 resetn pulsed low during data bit 4 -> outputs take reset values; a subsequent frame 0x7E is received correctly.
